// File: rtl/seg7_scan_counter.sv
// rtl/seg7_scan_counter.sv - multi-digit hex/BCD up/down counter with multiplexed 7-segment scan
module seg7_scan_counter #(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 4194304,
    parameter int SCAN_DIV       = 12000,
    parameter int DECIMAL        = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [3:0]            DIGIT_MAX  = (DECIMAL != 0) ? 4'd9 : 4'd15;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]         SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    // Inactive levels double as XOR masks that turn active-high patterns into the output polarity
    localparam logic [6:0]            SEG_IDLE   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_IDLE   = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]         presc;
    logic                  tick;
    logic [VW-1:0]         value_next;
    logic                  ripple;
    logic                  all_wrap;
    logic [VW-1:0]         load_clamped;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic [3:0]            cur_digit;
    logic [NUM_DIGITS-1:0] dig_onehot;

    // Active-high gfedcba pattern for one hex digit
    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'h0: seg_lut = 7'h3F;
            4'h1: seg_lut = 7'h06;
            4'h2: seg_lut = 7'h5B;
            4'h3: seg_lut = 7'h4F;
            4'h4: seg_lut = 7'h66;
            4'h5: seg_lut = 7'h6D;
            4'h6: seg_lut = 7'h7D;
            4'h7: seg_lut = 7'h07;
            4'h8: seg_lut = 7'h7F;
            4'h9: seg_lut = 7'h6F;
            4'hA: seg_lut = 7'h77;
            4'hB: seg_lut = 7'h7C;
            4'hC: seg_lut = 7'h39;
            4'hD: seg_lut = 7'h5E;
            4'hE: seg_lut = 7'h79;
            default: seg_lut = 7'h71;
        endcase
    endfunction

    // Tick on the last prescaler count of an enabled cycle; load swallows it
    assign tick = en && !load && (presc == PRESC_LAST);

    // Ripple carry/borrow through the digits; surviving ripple means every digit wrapped
    always_comb begin
        value_next = value;
        ripple     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ripple) begin
                if (up) begin
                    if (value[4*i +: 4] == DIGIT_MAX) begin
                        value_next[4*i +: 4] = 4'd0;
                    end else begin
                        value_next[4*i +: 4] = value[4*i +: 4] + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (value[4*i +: 4] == 4'd0) begin
                        value_next[4*i +: 4] = DIGIT_MAX;
                    end else begin
                        value_next[4*i +: 4] = value[4*i +: 4] - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        all_wrap = ripple;
    end

    // Saturate loaded digits above 9 when counting in BCD
    always_comb begin
        load_clamped = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((DECIMAL != 0) && (load_val[4*i +: 4] > 4'd9)) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    // Pick the digit under the scan index and its one-hot select
    always_comb begin
        cur_digit  = 4'd0;
        dig_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur_digit     = value[4*i +: 4];
                dig_onehot[i] = 1'b1;
            end
        end
    end

    // Count-step prescaler, frozen while disabled and cleared by load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (load) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    // Counter value and full-range wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            value <= load_clamped;
            wrap  <= 1'b0;
        end else if (tick) begin
            value <= value_next;
            wrap  <= all_wrap;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // Free-running digit scan, independent of the count enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Registered segment and digit drive, both taken from the same scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= SEG_IDLE;
            dig_sel <= DIG_IDLE;
        end else begin
            seg     <= seg_lut(cur_digit) ^ SEG_IDLE;
            dig_sel <= dig_onehot ^ DIG_IDLE;
        end
    end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb/tb_seg7_scan_counter.sv - scoreboard bench for hex and BCD scan counters
module tb_seg7_scan_counter;

    localparam int N  = 2;
    localparam int TD = 4;
    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] value_h, value_d;
    logic       wrap_h, wrap_d;
    logic [6:0] seg_h, seg_d;
    logic [1:0] dig_h, dig_d;

    seg7_scan_counter #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD), .DECIMAL(0),
                        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value_h), .wrap(wrap_h), .seg(seg_h), .dig_sel(dig_h));

    seg7_scan_counter #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD), .DECIMAL(1),
                        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_dec (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value_d), .wrap(wrap_d), .seg(seg_d), .dig_sel(dig_d));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vh; logic wh; logic [6:0] sh; logic [1:0] dh;
        logic [7:0] vd; logic wd; logic [6:0] sd; logic [1:0] dd;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference state: counts as plain integers, scan as slot/index
    int m_val[2];
    int m_p, m_s, m_idx;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic int digit_of(input int v, input int r, input int i);
        return (i == 0) ? (v % r) : ((v / r) % r);
    endfunction

    function automatic logic [7:0] pack(input int v, input int r);
        logic [3:0] lo, hi;
        lo = 4'(v % r);
        hi = 4'((v / r) % r);
        return {hi, lo};
    endfunction

    function automatic int from_lv(input logic [7:0] lv, input int r);
        int d0, d1;
        d0 = int'(lv[3:0]);
        d1 = int'(lv[7:4]);
        if (r == 10) begin
            if (d0 > 9) d0 = 9;
            if (d1 > 9) d1 = 9;
        end
        return d1 * r + d0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val[0] = 0;
        m_val[1] = 0;
        m_p = 0;
        m_s = 0;
        m_idx = 0;
    endtask

    // Predict the outputs after the coming rising edge and queue them
    task automatic model_step(input logic e_en, input logic e_up, input logic e_load,
                              input logic [7:0] lv);
        exp_t e;
        logic [6:0] s[2];
        logic [1:0] oh;
        logic w[2];
        logic tk;
        int r, mm;
        oh = 2'b01 << m_idx;
        for (int m = 0; m < 2; m++) begin
            r = (m == 0) ? 16 : 10;
            s[m] = ~enc(digit_of(m_val[m], r, m_idx));
        end
        m_s++;
        if (m_s == SD) begin
            m_s = 0;
            m_idx = (m_idx + 1) % N;
        end
        tk = 1'b0;
        if (e_load) begin
            m_p = 0;
        end else if (e_en) begin
            m_p++;
            if (m_p == TD) begin
                m_p = 0;
                tk = 1'b1;
            end
        end
        for (int m = 0; m < 2; m++) begin
            r = (m == 0) ? 16 : 10;
            mm = r * r;
            w[m] = 1'b0;
            if (e_load) begin
                m_val[m] = from_lv(lv, r);
            end else if (tk) begin
                if (e_up) begin
                    w[m] = (m_val[m] == mm - 1);
                    m_val[m] = (m_val[m] + 1) % mm;
                end else begin
                    w[m] = (m_val[m] == 0);
                    m_val[m] = (m_val[m] + mm - 1) % mm;
                end
            end
        end
        e.vh = pack(m_val[0], 16); e.wh = w[0]; e.sh = s[0]; e.dh = ~oh;
        e.vd = pack(m_val[1], 10); e.wd = w[1]; e.sd = s[1]; e.dd = ~oh;
        q.push_back(e);
    endtask

    task automatic cycle(input logic c_en, input logic c_up, input logic c_load,
                         input logic [7:0] lv);
        @(negedge clk);
        rst_n = 1'b1;
        en = c_en;
        up = c_up;
        load = c_load;
        load_val = lv;
        model_step(c_en, c_up, c_load, lv);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value_hex"}, value_h, 8'h00);
        check({tag, "_value_dec"}, value_d, 8'h00);
        check({tag, "_wrap_hex"}, wrap_h, 1'b0);
        check({tag, "_wrap_dec"}, wrap_d, 1'b0);
        check({tag, "_seg"}, {seg_d, seg_h}, 14'h3FFF);
        check({tag, "_dig"}, {dig_d, dig_h}, 4'hF);
    endtask

    // Asserted between clock edges so the checks see the asynchronous clear
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        load = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        model_reset();
    endtask

    task automatic run(input int n, input logic r_en, input logic r_up);
        for (int i = 0; i < n; i++) cycle(r_en, r_up, 1'b0, 8'h00);
    endtask

    // Monitor: one expectation per live clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("value_hex", value_h, e.vh);
                check("wrap_hex", wrap_h, e.wh);
                check("seg_hex", seg_h, e.sh);
                check("dig_hex", dig_h, e.dh);
                check("value_dec", value_d, e.vd);
                check("wrap_dec", wrap_d, e.wd);
                check("seg_dec", seg_d, e.sd);
                check("dig_dec", dig_d, e.dd);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] lv;
        model_reset();
        do_reset();

        // Scan pattern on a frozen 1E, then a count from reset
        cycle(1'b0, 1'b1, 1'b1, 8'h1E);
        run(10, 1'b0, 1'b1);
        do_reset();
        run(20, 1'b1, 1'b1);

        // Full-range wraps up and down, BCD carry, clamping
        cycle(1'b1, 1'b1, 1'b1, 8'hFE);
        run(12, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 8'h09);
        run(8, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        run(8, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'hAF);
        run(3, 1'b0, 1'b1);

        // Load colliding with a tick
        cycle(1'b1, 1'b1, 1'b1, 8'h00);
        run(3, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 8'h5A);
        run(9, 1'b1, 1'b1);

        // Reset just before a wrapping tick
        cycle(1'b1, 1'b1, 1'b1, 8'hFF);
        run(3, 1'b1, 1'b1);
        do_reset();
        run(10, 1'b1, 1'b1);

        // Randomized traffic
        begin
            logic r_up;
            r_up = 1'b1;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 19) == 0) r_up = ~r_up;
                case ($urandom_range(0, 9))
                    0, 1, 2: lv = 8'($urandom);
                    3: lv = 8'hFF;
                    4: lv = 8'h99;
                    5: lv = 8'h00;
                    6: lv = 8'hAF;
                    7: lv = 8'h98;
                    8: lv = 8'hFE;
                    default: lv = 8'h01;
                endcase
                cycle($urandom_range(0, 7) != 0, r_up, $urandom_range(0, 11) == 0, lv);
            end
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg7_scan_counter.md
SEG7_SCAN_COUNTER -- requirements
Module: seg7_scan_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4; number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 4194304; clk cycles per count step, minimum 2.
REQ-003 SHALL have parameter SCAN_DIV, default 12000; clk cycles per digit-scan slot, minimum 2.
REQ-004 SHALL have parameter DECIMAL, default 0; 0 selects radix-16 digits, 1 selects BCD (radix-10) digits.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1; 1 inverts the segment outputs.
REQ-006 SHALL have parameter DIG_ACTIVE_LOW, default 1; 1 inverts the digit-select outputs.
REQ-007 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit; reset, asynchronous assert, active-low.
REQ-009 SHALL have port en, input, 1 bit; count enable.
REQ-010 SHALL have port up, input, 1 bit; 1 selects count up, 0 selects count down.
REQ-011 SHALL have port load, input, 1 bit; synchronous load strobe.
REQ-012 SHALL have port load_val, input, 4*NUM_DIGITS bits; value to load, digit 0 in bits [3:0].
REQ-013 SHALL have port value, output, 4*NUM_DIGITS bits; registered current count, digit 0 in bits [3:0].
REQ-014 SHALL have port wrap, output, 1 bit; one-cycle pulse on full-range wrap.
REQ-015 SHALL have port seg, output, 7 bits; segments, seg[0]=a through seg[6]=g, registered.
REQ-016 SHALL have port dig_sel, output, NUM_DIGITS bits; one-hot digit enable, registered.

Function
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while en=1, SHALL hold while en=0, and SHALL raise an internal tick in the cycle it equals TICK_DIV-1 with en=1, then return to 0.
REQ-018 On tick with up=1, digit 0 SHALL increment; a digit at its maximum (9 if DECIMAL, else F) SHALL wrap to 0 and carry into the next digit.
REQ-019 On tick with up=0, digit 0 SHALL decrement; a digit at 0 SHALL wrap to its maximum and borrow from the next digit.
REQ-020 wrap SHALL pulse high for exactly one cycle, the cycle after value goes from all-maximum to all-zero (up) or from all-zero to all-maximum (down).
REQ-021 load=1 SHALL set value to load_val next cycle, SHALL clear the prescaler, and SHALL suppress any same-cycle tick and wrap; load has priority over tick.
REQ-022 With DECIMAL=1, any loaded digit above 9 SHALL be stored as 9.
REQ-023 Scan counter SHALL run continuously (independent of en) 0..SCAN_DIV-1; at SCAN_DIV-1 the scan index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-024 Each cycle, seg SHALL register the encoding of value digit[scan index]; dig_sel SHALL register the one-hot of scan index; both SHALL update in the same cycle.
REQ-025 Encoding SHALL be active-high, hex gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; the output SHALL be bitwise inverted when SEG_ACTIVE_LOW=1.
REQ-026 dig_sel SHALL be bitwise inverted when DIG_ACTIVE_LOW=1.

Reset
REQ-027 While rst_n=0, value, prescaler, scan counter, scan index and wrap SHALL be 0, and seg and dig_sel SHALL be all-inactive (all 1 with default parameters), independent of clk.
REQ-028 Reset asserted mid-count or mid-scan SHALL abort immediately with no wrap pulse; after release, the first tick SHALL occur TICK_DIV enabled cycles later.

Verification (NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2 unless stated)
REQ-029 Reset release, en=1, up=1, DECIMAL=0 -> value 00,01,02… advances every 4 cycles; after value FF the next step gives 00 with a single-cycle wrap=1.
REQ-030 DECIMAL=1, load 0x09 then count up -> 10 follows 09; load 0x99 and count up -> 00 with wrap; load 0xAF -> value 99.
REQ-031 DECIMAL=0, value 00, up=0 -> FF with wrap pulse; hold en=0 for 10 cycles -> value and prescaler frozen.
REQ-032 load asserted in the same cycle as tick with load_val 0x5A -> value 5A, no increment, wrap=0, next tick 4 cycles later.
REQ-033 value 0x1E -> seg/dig_sel alternate every 2 cycles between dig_sel=2'b10 with seg=~79 (E) and dig_sel=2'b01 with seg=~06 (1), defaults active-low.
REQ-034 rst_n pulsed low asynchronously mid-count -> outputs go to reset values without a clk edge; no wrap pulse.
